mem_4_port_arbiter: RTL
=======================

Name: mem_4_port_arbiter

Overview:
Shares the 4-port, 5-cycle-latency sequential memory between NREQ requesters.
- Each cycle, grants up to 4 requests round-robin and steers each onto one memory port.
- Tracks in-flight operations so responses return to the originating requester exactly LAT cycles after acceptance.
- Stalls reads and writes that would hit an address with a write still in the memory pipeline.

Parameters:
NREQ, 8, number of requesters (power of two, >= 4)
WIDTH, 32, data width
IDX_SIZE, 4, address width
LAT, 5, memory read/write latency in cycles; fixed pipeline depth of the tracker

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
req_val  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; a transfer occurs when req_val & req_ready
req_wen  in  NREQ  1 = write, 0 = read
req_addr  in  NREQ*IDX_SIZE  packed request addresses
req_wdata  in  NREQ*WIDTH  packed write data
resp_val  out  NREQ  one-cycle response pulse per requester
resp_data  out  NREQ*WIDTH  read data; 0 for write responses
mem_content_en  out  4  memory port enables
mem_write_en  out  4  memory write enables
mem_addr  out  4*IDX_SIZE  memory port addresses
mem_write_data  out  4*WIDTH  memory write data
mem_read_data  in  4*WIDTH  memory read outputs

Behaviour:
- Reset (reset==0 at posedge):
  - rr_ptr <= 0; all tracker stages invalid.
  - While reset is low, all req_ready, resp_val and mem_* enables are 0.
- Grant is combinational within the cycle:
  - Scan requesters in order rr_ptr, rr_ptr+1, ... (mod NREQ).
  - Grant the first up to 4 eligible requesters.
  - The k-th grant goes to memory port k (k=0..3). Unused ports have content_en=0, write_en=0, addr=0, data=0.
- Eligibility, requester i:
  - req_val[i] = 1; and
  - no write to req_addr[i] is in write-hazard stages 1..LAT-1 (issued 1..4 cycles ago; that data lands at the LAT-th edge); and
  - if any request already granted this cycle has the same address, both must be reads.
  - Earlier-scanned requests win; a same-cycle read and write to one address never co-issue.
- req_ready[i] = 1 iff requester i is granted. Ineligible requesters hold their request and retry the next cycle.
- rr_ptr update: if any grant, rr_ptr <= (index of last granted requester + 1) mod NREQ; otherwise unchanged.
- Tracker:
  - LAT-deep shift register per port, holding {valid, req_id, is_write}, shifting every cycle.
  - Stage 1 is loaded from this cycle's grants.
  - Write address and valid bits of stages 1..LAT-1 feed the hazard compare.
- Response: in cycle t+LAT after acceptance in cycle t, the tracker output for port k drives:
  - resp_val[req_id] = 1;
  - resp_data[req_id] = mem_read_data[k] for a read, 0 for a write.
- Requesters may issue back-to-back. Responses per requester are in order.
- At most one response per requester per cycle, since a requester can be granted at most once per cycle.
- Mid-operation reset clears the tracker immediately. In-flight responses are dropped; no resp_val after reset deasserts for pre-reset requests.
- Address out of range (>= 2^IDX_SIZE) cannot occur by width. No backpressure on responses.

Decomposition:
- Package mem_arb_pkg: NREQ_W = $clog2(NREQ), NPORTS = 4, LAT = 5, and typedef struct trk_entry_t {logic val; logic [NREQ_W-1:0] id; logic wr; logic [IDX_SIZE-1:0] addr;}.
- One sub-module, mem_arb_tracker: the per-port LAT-deep shift register plus the hazard-compare outputs.
- The grant/round-robin logic stays in the top module.

Test Plan:
- Reset held 3 cycles with req_val=all ones -> req_ready=0, resp_val=0, mem_content_en=0. After release, first cycle grants requesters 0..3 on ports 0..3; rr_ptr=4.
- Requester 2 writes 0xDEADBEEF to addr 5 in cycle 10; requester 6 reads addr 5 from cycle 11 ->
  - requester 6 stalled (req_ready=0) in cycles 11..14, granted in cycle 15;
  - resp_val[2] in cycle 15 with data 0;
  - resp_val[6] in cycle 20 with data 0xDEADBEEF.
- Requesters 1 and 3 both read addr 7 while requester 5 writes addr 7, same cycle, rr_ptr=0 -> reads 1 and 3 granted, write 5 stalled; next cycle write granted.
- All 8 requesters continuously valid on distinct addresses -> grants alternate {0-3}, {4-7}; each requester gets one response every 2 cycles, each 5 cycles after its grant.
- Reset asserted 2 cycles after 4 reads are accepted -> no resp_val for those reads after reset deasserts; tracker empty; rr_ptr=0.
- Read of an address never written, after reset -> response data equals the memory's contents. Compare against a scoreboard model over 10k random requests: no hazard violations; every accepted request gets exactly one response at +5.

Source files
------------

// File: rtl/mem_4_port_arbiter_pkg.sv
// Shared constants and tracker entry type for the 4-port, fixed-latency memory arbiter.
// Every other file of the arbiter imports this package.
package mem_arb_pkg;
  localparam int NREQ     = 8;
  localparam int WIDTH    = 32;
  localparam int IDX_SIZE = 4;
  localparam int LAT      = 5;
  localparam int NPORTS   = 4;
  localparam int NREQ_W   = $clog2(NREQ);
  localparam int PORT_W   = $clog2(NPORTS);

  typedef logic [NREQ_W-1:0]   req_id_t;
  typedef logic [IDX_SIZE-1:0] addr_t;
  typedef logic [WIDTH-1:0]    data_t;

  typedef struct packed {
    logic    val;
    req_id_t id;
    logic    wr;
    addr_t   addr;
  } trk_entry_t;

  // Two accesses to one address may share a cycle only when neither of them writes.
  function automatic logic addr_conflict(input trk_entry_t granted, input logic cand_wr,
                                         input addr_t cand_addr);
    return granted.val && (granted.addr == cand_addr) && (granted.wr || cand_wr);
  endfunction
endpackage

// File: rtl/mem_4_port_arbiter_if.sv
// Request/response and memory-port bundle of the arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the memory.
interface mem_arb_if import mem_arb_pkg::*; ();
  logic [NREQ-1:0]          req_val;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ-1:0]          req_wen;
  logic [NREQ*IDX_SIZE-1:0] req_addr;
  logic [NREQ*WIDTH-1:0]    req_wdata;
  logic [NREQ-1:0]          resp_val;
  logic [NREQ*WIDTH-1:0]    resp_data;
  logic [NPORTS-1:0]        mem_content_en;
  logic [NPORTS-1:0]        mem_write_en;
  logic [NPORTS*IDX_SIZE-1:0] mem_addr;
  logic [NPORTS*WIDTH-1:0]  mem_write_data;
  logic [NPORTS*WIDTH-1:0]  mem_read_data;

  modport slave (
    input  req_val, req_wen, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_val, resp_data,
           mem_content_en, mem_write_en, mem_addr, mem_write_data
  );

  modport master (
    output req_val, req_wen, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_val, resp_data,
           mem_content_en, mem_write_en, mem_addr, mem_write_data
  );
endinterface

// File: rtl/mem_4_port_arbiter_tracker.sv
// Per-port LAT-deep record of issued operations; the last stage routes responses and
// the younger stages flag requesters whose address still has a write in flight.
module mem_arb_tracker import mem_arb_pkg::*; (
  input  logic                     clk,
  input  logic                     reset,
  input  trk_entry_t [NPORTS-1:0]  i_load,
  input  logic [NREQ*IDX_SIZE-1:0] i_req_addr,
  output trk_entry_t [NPORTS-1:0]  o_retire,
  output logic [NREQ-1:0]          o_hazard
);

  trk_entry_t [NPORTS-1:0] r_stage [LAT];

  // NOTE: only the valid bits matter for function, but clearing whole entries keeps the
  // retired id/address deterministic right after reset; this is a small register file,
  // not a RAM, so a full synchronous clear is cheap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int s = 0; s < LAT; s++) r_stage[s] <= '0;
    end else begin
      r_stage[0] <= i_load;
      for (int s = 1; s < LAT; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  assign o_retire = r_stage[LAT-1];

  // The oldest stage is excluded: its write commits before a same-cycle access reaches memory.
  always_comb begin
    o_hazard = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int s = 0; s < LAT-1; s++) begin
        for (int k = 0; k < NPORTS; k++) begin
          if (r_stage[s][k].val && r_stage[s][k].wr &&
              (r_stage[s][k].addr == i_req_addr[i*IDX_SIZE +: IDX_SIZE]))
            o_hazard[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_4_port_arbiter.sv
// Round-robin arbiter sharing a 4-port, LAT-cycle memory between NREQ requesters,
// with write-hazard stalling and in-order response routing back to each requester.
module mem_4_port_arbiter import mem_arb_pkg::*; (
  input logic      clk,
  input logic      reset,
  mem_arb_if.slave bus
);

  req_id_t                 r_rr_ptr;
  req_id_t                 w_last;
  logic [NREQ-1:0]         w_grant;
  logic [NREQ-1:0]         w_hazard;
  trk_entry_t [NPORTS-1:0] w_load;
  trk_entry_t [NPORTS-1:0] w_retire;
  data_t [NPORTS-1:0]      w_port_wdata;

  mem_arb_tracker u_tracker (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_req_addr (bus.req_addr),
    .o_retire   (w_retire),
    .o_hazard   (w_hazard)
  );

  // Scan from rr_ptr; the k-th eligible requester lands on memory port k.
  always_comb begin : grant_scan
    req_id_t         w_idx;
    addr_t           w_addr;
    logic            w_wen;
    logic            w_ok;
    logic [PORT_W:0] w_cnt;
    // NOTE: every variable gets a value before any branch, so no path leaves one
    // unassigned and no latch is inferred.
    w_load       = '0;
    w_port_wdata = '0;
    w_grant      = '0;
    w_last       = r_rr_ptr;
    w_cnt        = '0;
    w_idx        = '0;
    w_addr       = '0;
    w_wen        = 1'b0;
    w_ok         = 1'b0;
    for (int s = 0; s < NREQ; s++) begin
      w_idx  = r_rr_ptr + req_id_t'(s);
      w_addr = bus.req_addr[int'(w_idx)*IDX_SIZE +: IDX_SIZE];
      w_wen  = bus.req_wen[w_idx];
      w_ok   = reset && bus.req_val[w_idx] && !w_hazard[w_idx] &&
               (w_cnt < (PORT_W+1)'(NPORTS));
      for (int k = 0; k < NPORTS; k++) begin
        if (addr_conflict(w_load[k], w_wen, w_addr)) w_ok = 1'b0;
      end
      if (w_ok) begin
        w_load[w_cnt[PORT_W-1:0]]       = '{val: 1'b1, id: w_idx, wr: w_wen, addr: w_addr};
        w_port_wdata[w_cnt[PORT_W-1:0]] = w_wen ? bus.req_wdata[int'(w_idx)*WIDTH +: WIDTH]
                                                : '0;
        w_grant[w_idx] = 1'b1;
        w_last         = w_idx;
        w_cnt          = w_cnt + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset)          r_rr_ptr <= '0;
    else if (|w_grant)   r_rr_ptr <= w_last + req_id_t'(1);
  end

  assign bus.req_ready = w_grant;

  for (genvar k = 0; k < NPORTS; k++) begin : g_port
    assign bus.mem_content_en[k]                  = w_load[k].val;
    assign bus.mem_write_en[k]                    = w_load[k].val & w_load[k].wr;
    assign bus.mem_addr[k*IDX_SIZE +: IDX_SIZE]   = w_load[k].addr;
    assign bus.mem_write_data[k*WIDTH +: WIDTH]   = w_port_wdata[k];
  end

  // Each requester owns at most one retiring entry per cycle, so lanes never collide.
  always_comb begin : resp_route
    bus.resp_val  = '0;
    bus.resp_data = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (reset && w_retire[k].val) begin
        bus.resp_val[w_retire[k].id] = 1'b1;
        bus.resp_data[int'(w_retire[k].id)*WIDTH +: WIDTH] =
          w_retire[k].wr ? '0 : bus.mem_read_data[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule
